vga_timing_scheduler: RTL and testbench

Generates and sequences the VGA raster: owns the column/row counters, derives HSync/VSync/active-video from them, and starts and stops scanout only on frame boundaries. It also schedules display-pattern changes from a requester through a valid/ready handshake so that a new pattern takes effect on the first pixel of a frame, never mid-frame. It sits between the control logic (buttons/UART command decoder) and the pixel generators that consume counts and sync.

---
 rtl/vga_timing_scheduler_if.sv | 32 +++
 rtl/vga_timing_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_vga_timing_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_scheduler_if.sv
// vga_timing_scheduler_if
// Bundles everything exchanged between the raster scheduler and its
// neighbours except clock and reset.
//   Control side (master drives): i_Enable, i_Pattern, i_Pattern_Valid
//   Scheduler side (slave drives): o_Pattern_Ready, o_Pattern, o_Col_Count,
//     o_Row_Count, o_HSync, o_VSync, o_Active_Video, o_Frame_Start, o_Running
interface vga_timing_scheduler_if;
  logic       i_Enable;
  logic [3:0] i_Pattern;
  logic       i_Pattern_Valid;
  logic       o_Pattern_Ready;
  logic [3:0] o_Pattern;
  logic [9:0] o_Col_Count;
  logic [9:0] o_Row_Count;
  logic       o_HSync;
  logic       o_VSync;
  logic       o_Active_Video;
  logic       o_Frame_Start;
  logic       o_Running;

  modport master (
    output i_Enable, i_Pattern, i_Pattern_Valid,
    input  o_Pattern_Ready, o_Pattern, o_Col_Count, o_Row_Count,
           o_HSync, o_VSync, o_Active_Video, o_Frame_Start, o_Running
  );

  modport slave (
    input  i_Enable, i_Pattern, i_Pattern_Valid,
    output o_Pattern_Ready, o_Pattern, o_Col_Count, o_Row_Count,
           o_HSync, o_VSync, o_Active_Video, o_Frame_Start, o_Running
  );
endinterface

// File: rtl/vga_timing_scheduler.sv
// vga_timing_scheduler
// Owns the VGA column/row counters, decodes sync and active-video from them,
// starts/stops scanout only on frame boundaries and defers pattern changes
// to the first pixel of a frame through a one-entry pending register.
// Ports:
//   i_Clk  - pixel clock
//   i_Rst  - synchronous active-high reset
//   bus    - vga_timing_scheduler_if.slave (enable, pattern handshake,
//            counts, syncs, active video, frame start, running)
// Every output is a flop; decode is computed from the next count so each
// registered output lines up with the count shown in the same cycle.
module vga_timing_scheduler #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  vga_timing_scheduler_if.slave  bus
);

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] COL_ACT  = 10'(ACTIVE_COLS);
  localparam logic [9:0] ROW_ACT  = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HS_FIRST = 10'(ACTIVE_COLS + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(ACTIVE_COLS + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(ACTIVE_ROWS + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(ACTIVE_ROWS + V_FRONT + V_SYNC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       frame_start_q, frame_start_d;
  logic       running_q, running_d;
  logic [3:0] pattern_q, pattern_d;
  logic       ready_q, ready_d;
  logic       pend_valid_q, pend_valid_d;
  logic [3:0] pend_q, pend_d;
  logic       frame_end_s;
  logic       apply_s;

  assign frame_end_s = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // Next state and raster counters.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        col_d = 10'd0;
        row_d = 10'd0;
        if (bus.i_Enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        // Stopping is only honoured on the last pixel of a frame, so a
        // frame is never truncated; otherwise counting never pauses.
        if (!bus.i_Enable && frame_end_s) begin
          state_d = ST_IDLE;
          col_d   = 10'd0;
          row_d   = 10'd0;
        end else begin
          if (col_q == COL_LAST) begin
            col_d = 10'd0;
            if (row_q == ROW_LAST) begin
              row_d = 10'd0;
            end else begin
              row_d = row_q + 10'd1;
            end
          end else begin
            col_d = col_q + 10'd1;
            row_d = row_q;
          end
          if (bus.i_Enable) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = 10'd0;
        row_d   = 10'd0;
      end
    endcase
  end

  // Output decode from the next count, plus pattern scheduling.
  always_comb begin
    running_d     = (state_d != ST_IDLE);
    frame_start_d = running_d && (col_d == 10'd0) && (row_d == 10'd0);
    if (running_d) begin
      active_d = (col_d < COL_ACT) && (row_d < ROW_ACT);
      hsync_d  = !((col_d >= HS_FIRST) && (col_d <= HS_LAST));
      vsync_d  = !((row_d >= VS_FIRST) && (row_d <= VS_LAST));
    end else begin
      active_d = 1'b0;
      hsync_d  = 1'b1;
      vsync_d  = 1'b1;
    end

    pattern_d    = pattern_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    // While idle nothing is on screen, so a pending pattern lands at once;
    // otherwise only on the cycle the count enters (0,0).
    apply_s = pend_valid_q && ((state_q == ST_IDLE) || frame_start_d);
    if (apply_s) begin
      pattern_d    = pend_q;
      pend_valid_d = 1'b0;
    end else if (bus.i_Pattern_Valid && !pend_valid_q) begin
      // Accepted even on a boundary cycle: it then waits a full frame.
      pend_valid_d = 1'b1;
      pend_d       = bus.i_Pattern;
    end else begin
      pend_valid_d = pend_valid_q;
    end
    ready_d = !pend_valid_d;
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q       <= ST_IDLE;
      col_q         <= 10'd0;
      row_q         <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
      pattern_q     <= 4'd0;
      ready_q       <= 1'b1;
      pend_valid_q  <= 1'b0;
      pend_q        <= 4'd0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
      pattern_q     <= pattern_d;
      ready_q       <= ready_d;
      pend_valid_q  <= pend_valid_d;
      pend_q        <= pend_d;
    end
  end

  assign bus.o_Col_Count     = col_q;
  assign bus.o_Row_Count     = row_q;
  assign bus.o_HSync         = hsync_q;
  assign bus.o_VSync         = vsync_q;
  assign bus.o_Active_Video  = active_q;
  assign bus.o_Frame_Start   = frame_start_q;
  assign bus.o_Running       = running_q;
  assign bus.o_Pattern       = pattern_q;
  assign bus.o_Pattern_Ready = ready_q;

endmodule

// File: tb/tb_vga_timing_scheduler.sv
// tb_vga_timing_scheduler
// Scoreboard bench for vga_timing_scheduler using a reduced raster
// (40x20 total, 32x12 active) so several frames fit in a short run.
// Expected outputs are pushed every clock from a behavioural model and
// popped/compared on the following falling edge; directed checks use
// constants derived from the raster geometry.
module tb_vga_timing_scheduler;
  localparam int TC = 40;
  localparam int TR = 20;
  localparam int AC = 32;
  localparam int AR = 12;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int VF = 2;
  localparam int VS = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  vga_timing_scheduler_if vif();

  vga_timing_scheduler #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT(HF), .H_SYNC(HS), .V_FRONT(VF), .V_SYNC(VS)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: 0=idle 1=run 2=drain.
  int         m_st;
  int         m_col;
  int         m_row;
  logic [3:0] m_pat;
  logic [3:0] m_pend;
  logic       m_pv;
  logic       m_fs;
  logic       m_acc;
  logic       m_was_idle;
  logic       m_old_pv;
  logic       m_run;
  logic [31:0] sb_q[$];

  function automatic logic [31:0] pack(input int col, input int row, input logic hs,
                                       input logic vs, input logic av, input logic fs,
                                       input logic run, input logic [3:0] pat, input logic rdy);
    logic [31:0] v;
    v = {2'b00, 10'(col), 10'(row), hs, vs, av, fs, run, pat, rdy};
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_col = 0; m_row = 0; m_pat = 4'd0; m_pend = 4'd0; m_pv = 1'b0; m_fs = 1'b0;
    end else begin
      m_acc      = vif.i_Pattern_Valid && !m_pv;
      m_was_idle = (m_st == 0);
      m_old_pv   = m_pv;
      if (m_st == 0) begin
        if (vif.i_Enable) m_st = 1;
      end else if (m_col == TC-1 && m_row == TR-1 && !vif.i_Enable) begin
        m_st = 0; m_col = 0; m_row = 0;
      end else begin
        m_col = m_col + 1;
        if (m_col == TC) begin
          m_col = 0;
          m_row = (m_row == TR-1) ? 0 : m_row + 1;
        end
        m_st = vif.i_Enable ? 1 : 2;
      end
      m_fs = (m_st != 0) && m_col == 0 && m_row == 0;
      if (m_old_pv && (m_fs || m_was_idle)) begin
        m_pat = m_pend;
        m_pv  = 1'b0;
      end
      if (m_acc) begin
        m_pv   = 1'b1;
        m_pend = vif.i_Pattern;
      end
    end
    m_run = (m_st != 0);
    sb_q.push_back(pack(m_col, m_row,
                        !(m_run && m_col >= AC+HF && m_col < AC+HF+HS),
                        !(m_run && m_row >= AR+VF && m_row < AR+VF+VS),
                        m_run && m_col < AC && m_row < AR,
                        m_fs, m_run, m_pat, !m_pv));
  end

  // Pop one expectation per clock and compare against the DUT.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      check("scoreboard", pack(int'(vif.o_Col_Count), int'(vif.o_Row_Count), vif.o_HSync,
                               vif.o_VSync, vif.o_Active_Video, vif.o_Frame_Start,
                               vif.o_Running, vif.o_Pattern, vif.o_Pattern_Ready),
            sb_q.pop_front());
    end
  end

  task automatic wait_pos(input int c, input int r);
    int   n;
    logic timed_out;
    n = 0;
    while (!(int'(vif.o_Col_Count) == c && int'(vif.o_Row_Count) == r) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= 5000);
    check("wait_pos_timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic wait_fs();
    int   n;
    logic timed_out;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vif.o_Frame_Start && n < 5000);
    timed_out = (n >= 5000);
    check("wait_fs_timeout", 32'(timed_out), 32'd0);
  endtask

  initial begin
    int cnt;
    int av_cnt;
    int hs_cnt;
    int vs_cnt;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    vif.i_Enable = 1'b0;
    vif.i_Pattern = 4'd0;
    vif.i_Pattern_Valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(vif.o_Col_Count), 32'd0);
    check("rst_ready", 32'(vif.o_Pattern_Ready), 32'd1);
    check("rst_hsync", 32'(vif.o_HSync), 32'd1);
    check("rst_running", 32'(vif.o_Running), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    vif.i_Enable = 1'b1;
    @(negedge clk);
    check("en_fs", 32'(vif.o_Frame_Start), 32'd1);
    check("en_row", 32'(vif.o_Row_Count), 32'd0);
    check("en_running", 32'(vif.o_Running), 32'd1);

    // One full frame: period and decode populations.
    cnt = 0; av_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    do begin
      av_cnt += int'(vif.o_Active_Video);
      hs_cnt += int'(!vif.o_HSync);
      vs_cnt += int'(!vif.o_VSync);
      @(negedge clk);
      cnt++;
    end while (!vif.o_Frame_Start && cnt < 2000);
    check("frame_period", 32'(cnt), 32'(TC*TR));
    check("active_cycles", 32'(av_cnt), 32'(AC*AR));
    check("hsync_cycles", 32'(hs_cnt), 32'(HS*TR));
    check("vsync_cycles", 32'(vs_cnt), 32'(VS*TC));

    // Pattern 5 mid-frame; a second request while pending is refused.
    wait_pos(0, 6);
    vif.i_Pattern = 4'h5; vif.i_Pattern_Valid = 1'b1;
    @(negedge clk);
    check("pend_ready_low", 32'(vif.o_Pattern_Ready), 32'd0);
    vif.i_Pattern = 4'h9;
    repeat (3) @(negedge clk);
    check("second_refused", 32'(vif.o_Pattern_Ready), 32'd0);
    vif.i_Pattern_Valid = 1'b0;
    wait_fs();
    check("pat5_applied", 32'(vif.o_Pattern), 32'h5);
    check("pat5_ready", 32'(vif.o_Pattern_Ready), 32'd1);

    // Handshake coinciding with entry to (0,0) waits one more frame.
    wait_pos(TC-1, TR-1);
    vif.i_Pattern = 4'h3; vif.i_Pattern_Valid = 1'b1;
    @(negedge clk);
    vif.i_Pattern_Valid = 1'b0;
    check("bnd_fs", 32'(vif.o_Frame_Start), 32'd1);
    check("bnd_pat_kept", 32'(vif.o_Pattern), 32'h5);
    check("bnd_ready_low", 32'(vif.o_Pattern_Ready), 32'd0);
    wait_fs();
    check("pat3_applied", 32'(vif.o_Pattern), 32'h3);

    // Drain then re-enable without disturbance, then a real stop.
    wait_pos(0, 5);
    vif.i_Enable = 1'b0;
    @(negedge clk);
    check("drain_running", 32'(vif.o_Running), 32'd1);
    wait_pos(0, 10);
    vif.i_Enable = 1'b1;
    @(negedge clk);
    check("reen_col", 32'(vif.o_Col_Count), 32'd1);
    check("reen_row", 32'(vif.o_Row_Count), 32'd10);
    wait_pos(0, 12);
    vif.i_Enable = 1'b0;
    wait_pos(TC-1, TR-1);
    check("last_pix_running", 32'(vif.o_Running), 32'd1);
    @(negedge clk);
    check("stop_running", 32'(vif.o_Running), 32'd0);
    check("stop_col", 32'(vif.o_Col_Count), 32'd0);
    check("stop_vsync", 32'(vif.o_VSync), 32'd1);
    check("stop_fs", 32'(vif.o_Frame_Start), 32'd0);

    // In IDLE a pending pattern lands on the next cycle.
    vif.i_Pattern = 4'hA; vif.i_Pattern_Valid = 1'b1;
    @(negedge clk);
    vif.i_Pattern_Valid = 1'b0;
    check("idle_pend", 32'(vif.o_Pattern_Ready), 32'd0);
    @(negedge clk);
    check("idle_apply", 32'(vif.o_Pattern), 32'hA);

    // Reset mid-frame discards a pending pattern.
    vif.i_Enable = 1'b1;
    wait_pos(25, 8);
    vif.i_Pattern = 4'h7; vif.i_Pattern_Valid = 1'b1;
    @(negedge clk);
    vif.i_Pattern_Valid = 1'b0;
    check("rst_pend_ready", 32'(vif.o_Pattern_Ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_col", 32'(vif.o_Col_Count), 32'd0);
    check("abort_row", 32'(vif.o_Row_Count), 32'd0);
    check("abort_running", 32'(vif.o_Running), 32'd0);
    check("abort_pattern", 32'(vif.o_Pattern), 32'd0);
    check("abort_ready", 32'(vif.o_Pattern_Ready), 32'd1);
    rst = 1'b0;
    vif.i_Enable = 1'b0;
    repeat (2) @(negedge clk);
    check("pend_lost", 32'(vif.o_Pattern), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
